regfile_seq_ctrl: RTL and testbench

- Sequencer and port owner for the single-cycle core's 32x32 register file (`register`).
- After reset it scrubs x1..x31 to zero while stalling the core.
- It then passes the core's read/write ports straight through.
- On request, it stalls the core and streams every register over a valid/ready dump port. This replaces the ad-hoc "display all registers" done hook with a hardware dump usable by debug and testbenches.

---
 rtl/regfile_seq_ctrl_if.sv | 40 ++++
 rtl/regfile_seq_ctrl.sv | 100 ++++++++++
 tb/tb_regfile_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_ctrl_if.sv
// Bundles the core-side ports, the dump stream and the register-file ports of regfile_seq_ctrl.
// The master modport is the sequencer. The slave modport is its environment (core, dump consumer, register file).
interface regfile_seq_ctrl_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
) ();
    logic            core_we;
    logic [AW-1:0]   core_wa;
    logic [XLEN-1:0] core_wd;
    logic [AW-1:0]   core_ra1;
    logic [AW-1:0]   core_ra2;
    logic            stall;
    logic            scrub_done;
    logic            dump_req;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;
    logic            dump_last;
    logic            rf_we3;
    logic [AW-1:0]   rf_a1;
    logic [AW-1:0]   rf_a2;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd3;
    logic [XLEN-1:0] rf_rd1;

    modport master (
        input  core_we, core_wa, core_wd, core_ra1, core_ra2,
        input  dump_req, dump_ready, rf_rd1,
        output stall, scrub_done, dump_valid, dump_idx, dump_data, dump_last,
        output rf_we3, rf_a1, rf_a2, rf_a3, rf_wd3
    );

    modport slave (
        output core_we, core_wa, core_wd, core_ra1, core_ra2,
        output dump_req, dump_ready, rf_rd1,
        input  stall, scrub_done, dump_valid, dump_idx, dump_data, dump_last,
        input  rf_we3, rf_a1, rf_a2, rf_a3, rf_wd3
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Register-file port owner for the single-cycle core.
// It scrubs x1..x31 after reset, then passes the core ports through, and on request streams every register over a valid/ready dump port.
module regfile_seq_ctrl #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_seq_ctrl_if.master   bus
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        SCRUB = 2'd0,
        RUN   = 2'd1,
        DUMP  = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          scrub_done_q;

    // cnt_q holds the scrub write address in SCRUB and the beat index in DUMP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SCRUB;
            cnt_q        <= AW'(1);
            scrub_done_q <= 1'b0;
        end else begin
            case (state_q)
                SCRUB: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q      <= RUN;
                        scrub_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.dump_req) begin
                        state_q <= DUMP;
                        cnt_q   <= '0;
                    end
                end
                DUMP: begin
                    if (bus.dump_ready) begin
                        if (cnt_q == LAST_IDX) begin
                            state_q <= RUN;
                        end else begin
                            cnt_q <= cnt_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= SCRUB;
                    cnt_q   <= AW'(1);
                end
            endcase
        end
    end

    always_comb begin
        bus.stall      = 1'b1;
        bus.rf_we3     = 1'b0;
        bus.rf_a1      = '0;
        bus.rf_a2      = '0;
        bus.rf_a3      = '0;
        bus.rf_wd3     = '0;
        bus.dump_valid = 1'b0;
        bus.dump_idx   = cnt_q;
        bus.dump_data  = '0;
        bus.dump_last  = 1'b0;
        case (state_q)
            SCRUB: begin
                bus.rf_we3 = 1'b1;
                bus.rf_a3  = cnt_q;
            end
            RUN: begin
                bus.stall  = 1'b0;
                bus.rf_we3 = bus.core_we;
                bus.rf_a3  = bus.core_wa;
                bus.rf_wd3 = bus.core_wd;
                bus.rf_a1  = bus.core_ra1;
                bus.rf_a2  = bus.core_ra2;
            end
            DUMP: begin
                // Core writes are dropped here; x0 reads as zero whatever the array holds.
                bus.rf_a1      = cnt_q;
                bus.rf_a2      = bus.core_ra2;
                bus.dump_valid = 1'b1;
                bus.dump_data  = (cnt_q == '0) ? '0 : bus.rf_rd1;
                bus.dump_last  = (cnt_q == LAST_IDX);
            end
            default: ;
        endcase
    end

    assign bus.scrub_done = scrub_done_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl with a behavioural 32x32 register file.
module tb_regfile_seq_ctrl;
    logic clk;
    logic rst_n;

    regfile_seq_ctrl_if #(.AW(5), .XLEN(32)) bus ();

    regfile_seq_ctrl #(.NREGS(32), .AW(5), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read. x0 is not protected here.
    logic [31:0] rf_mem [32];
    initial for (int i = 0; i < 32; i++) rf_mem[i] = 32'hdead_0000 | 32'(i);
    always @(posedge clk) if (bus.rf_we3) rf_mem[bus.rf_a3] <= bus.rf_wd3;
    assign bus.rf_rd1 = rf_mem[bus.rf_a1];

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_regs [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        exp_we3;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd3;
        logic [4:0]  exp_a1;
        logic [4:0]  exp_a2;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first cycle after reset release (cnt == 1); returns in the first RUN cycle.
    task automatic scrub_seq();
        for (int i = 1; i < 32; i++) begin
            #1;
            chk($sformatf("scrub_we3[%0d]", i), 32'(bus.rf_we3), 32'd1);
            chk($sformatf("scrub_a3[%0d]", i), 32'(bus.rf_a3), 32'(i));
            chk($sformatf("scrub_wd3[%0d]", i), bus.rf_wd3, 32'd0);
            chk($sformatf("scrub_stall[%0d]", i), 32'(bus.stall), 32'd1);
            chk($sformatf("scrub_valid[%0d]", i), 32'(bus.dump_valid), 32'd0);
            tick();
        end
        #1;
        chk("run_stall", 32'(bus.stall), 32'd0);
        chk("run_scrub_done", 32'(bus.scrub_done), 32'd1);
        chk("run_valid", 32'(bus.dump_valid), 32'd0);
    endtask

    // Starts in a RUN cycle; raises dump_req together with an optional core write.
    task automatic do_dump(input logic rwe, input logic [4:0] rwa, input logic [31:0] rwd,
                           input int hold_idx, input int hold_n, input logic wr_in_dump,
                           input int rst_idx);
        bus.core_we = rwe; bus.core_wa = rwa; bus.core_wd = rwd;
        bus.dump_req = 1'b1; bus.dump_ready = 1'b1;
        #1;
        chk("req_stall", 32'(bus.stall), 32'd0);
        chk("req_we3", 32'(bus.rf_we3), 32'(rwe));
        tick();
        bus.core_we = 1'b0;
        bus.dump_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == hold_idx) begin
                for (int h = 0; h < hold_n; h++) begin
                    bus.dump_ready = 1'b0;
                    #1;
                    chk($sformatf("hold_valid[%0d]", h), 32'(bus.dump_valid), 32'd1);
                    chk($sformatf("hold_idx[%0d]", h), 32'(bus.dump_idx), 32'(i));
                    chk($sformatf("hold_data[%0d]", h), bus.dump_data, exp_regs[i]);
                    tick();
                end
            end
            bus.dump_ready = 1'b1;
            if (wr_in_dump) begin
                bus.core_we = 1'b1; bus.core_wa = 5'd4; bus.core_wd = 32'h0bad_0004;
            end
            #1;
            chk($sformatf("beat_valid[%0d]", i), 32'(bus.dump_valid), 32'd1);
            chk($sformatf("beat_idx[%0d]", i), 32'(bus.dump_idx), 32'(i));
            chk($sformatf("beat_data[%0d]", i), bus.dump_data, exp_regs[i]);
            chk($sformatf("beat_last[%0d]", i), 32'(bus.dump_last), 32'(i == 31));
            chk($sformatf("beat_stall[%0d]", i), 32'(bus.stall), 32'd1);
            chk($sformatf("beat_we3[%0d]", i), 32'(bus.rf_we3), 32'd0);
            if (i == rst_idx) begin
                rst_n = 1'b0;
                bus.core_we = 1'b0;
                tick();
                return;
            end
            tick();
        end
        bus.core_we = 1'b0;
        #1;
        chk("resume_stall", 32'(bus.stall), 32'd0);
        chk("resume_valid", 32'(bus.dump_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd1, 32'h1234_5678, 5'd3,  5'd0,  1'b1, 5'd1, 32'h1234_5678, 5'd3,  5'd0,  32'h0};
        vecs[1] = '{1'b1, 5'd2, 32'h8765_4321, 5'd1,  5'd2,  1'b1, 5'd2, 32'h8765_4321, 5'd1,  5'd2,  32'h1234_5678};
        vecs[2] = '{1'b0, 5'd7, 32'hffff_ffff, 5'd2,  5'd1,  1'b0, 5'd7, 32'hffff_ffff, 5'd2,  5'd1,  32'h8765_4321};
        vecs[3] = '{1'b0, 5'd0, 32'h0,         5'd7,  5'd31, 1'b0, 5'd0, 32'h0,         5'd7,  5'd31, 32'h0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         5'd31, 5'd30, 1'b0, 5'd0, 32'h0,         5'd31, 5'd30, 32'h0};

        rst_n = 1'b0;
        bus.core_we = 1'b0; bus.core_wa = '0; bus.core_wd = '0;
        bus.core_ra1 = '0; bus.core_ra2 = '0;
        bus.dump_req = 1'b0; bus.dump_ready = 1'b0;

        // Reset held for two edges, then full scrub
        tick();
        tick();
        #1;
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_valid", 32'(bus.dump_valid), 32'd0);
        chk("rst_last", 32'(bus.dump_last), 32'd0);
        chk("rst_scrub_done", 32'(bus.scrub_done), 32'd0);
        rst_n = 1'b1;
        scrub_seq();

        // RUN pass-through vectors
        for (int v = 0; v < 5; v++) begin
            bus.core_we = vecs[v].we; bus.core_wa = vecs[v].wa; bus.core_wd = vecs[v].wd;
            bus.core_ra1 = vecs[v].ra1; bus.core_ra2 = vecs[v].ra2;
            #1;
            chk($sformatf("vec%0d_we3", v), 32'(bus.rf_we3), 32'(vecs[v].exp_we3));
            chk($sformatf("vec%0d_a3", v), 32'(bus.rf_a3), 32'(vecs[v].exp_a3));
            chk($sformatf("vec%0d_wd3", v), bus.rf_wd3, vecs[v].exp_wd3);
            chk($sformatf("vec%0d_a1", v), 32'(bus.rf_a1), 32'(vecs[v].exp_a1));
            chk($sformatf("vec%0d_a2", v), 32'(bus.rf_a2), 32'(vecs[v].exp_a2));
            chk($sformatf("vec%0d_rd1", v), bus.rf_rd1, vecs[v].exp_rd1);
            chk($sformatf("vec%0d_stall", v), 32'(bus.stall), 32'd0);
            tick();
        end
        bus.core_we = 1'b0;

        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
        exp_regs[1] = 32'h1234_5678;
        exp_regs[2] = 32'h8765_4321;

        // Plain dump, always ready
        do_dump(1'b0, 5'd0, 32'h0, -1, 0, 1'b0, -1);

        // Backpressure at idx 5, with same-cycle write of x5
        exp_regs[5] = 32'h0000_5555;
        do_dump(1'b1, 5'd5, 32'h0000_5555, 5, 3, 1'b0, -1);

        // x0 write with request; core writes during the dump are dropped
        do_dump(1'b1, 5'd0, 32'hdead_beef, -1, 0, 1'b1, -1);

        // Same-cycle x3 write is visible; x4 stays zero
        exp_regs[3] = 32'ha5a5_a5a5;
        do_dump(1'b1, 5'd3, 32'ha5a5_a5a5, -1, 0, 1'b0, -1);

        // Reset mid-dump at idx 10, dump_req held through the scrub
        do_dump(1'b0, 5'd0, 32'h0, -1, 0, 1'b0, 10);
        bus.dump_req = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.dump_valid), 32'd0);
        chk("mid_rst_scrub_done", 32'(bus.scrub_done), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd1);
        chk("mid_rst_a3", 32'(bus.rf_a3), 32'd1);
        rst_n = 1'b1;
        scrub_seq();
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
        do_dump(1'b0, 5'd0, 32'h0, -1, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
